// File: rtl/led_pwm_fade_if.sv
// Pattern/brightness/enable inputs and PWM pin outputs of the LED fade stage.
// Signal names match the block's pin list, so the direction suffixes stay.
interface led_pwm_fade_if #(
    parameter int LED_NUM  = 8,
    parameter int PWM_BITS = 8
);
    logic [LED_NUM-1:0]  pat_i;
    logic [PWM_BITS-1:0] bright_i;
    logic                en_i;
    logic [LED_NUM-1:0]  LED_o;
    logic                frame_o;

    modport master (
        output pat_i,
        output bright_i,
        output en_i,
        input  LED_o,
        input  frame_o
    );

    modport slave (
        input  pat_i,
        input  bright_i,
        input  en_i,
        output LED_o,
        output frame_o
    );
endinterface

// File: rtl/led_pwm_fade.sv
// Per-LED PWM brightness with an optional linear fade trail after a pattern bit clears.
// Define LED_PWM_FADE_TRAIL_EN to build the decay trail; otherwise levels are pattern x brightness.
module led_pwm_fade #(
    parameter int CLK_FREQ    = 300_000_000,
    parameter int LED_NUM     = 8,
    parameter int PWM_BITS    = 8,
    parameter int PWM_FREQ    = 1_000,
    parameter int FADE_FRAMES = 8,
    parameter int DECAY       = 16
) (
    input logic           CLK_i,
    input logic           RST_i,
    led_pwm_fade_if.slave bus
);

    localparam int PRE_RAW = CLK_FREQ / (PWM_FREQ * (2 ** PWM_BITS));
    localparam int PRE_DIV = (PRE_RAW < 1) ? 1 : PRE_RAW;
    localparam int PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);

    if (FADE_FRAMES < 1 || DECAY < 1 || LED_NUM < 1 || PWM_BITS < 1) begin : g_bad_cfg
        $error("led_pwm_fade: FADE_FRAMES, DECAY, LED_NUM and PWM_BITS must all be >= 1");
    end

    logic [PRE_W-1:0]    pre;
    logic                tick;
    logic [PWM_BITS-1:0] cnt;
    logic                frame_bnd;
    logic                frame_q;
    logic [LED_NUM-1:0]  led_q;
    logic [PWM_BITS-1:0] level    [LED_NUM];
    logic [PWM_BITS-1:0] level_nx [LED_NUM];

    assign tick      = (pre == PRE_LAST);
    assign frame_bnd = tick & (cnt == '1);

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // cnt wraps naturally from all-ones back to zero
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            frame_q <= 1'b0;
        end else begin
            frame_q <= frame_bnd;
        end
    end

`ifdef LED_PWM_FADE_TRAIL_EN
    localparam int FC_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    localparam logic [FC_W-1:0]     FC_LAST = FC_W'(FADE_FRAMES - 1);
    localparam logic [PWM_BITS-1:0] DECAY_L = PWM_BITS'(DECAY);

    logic [FC_W-1:0] fcnt;
    logic            decay_step;

    assign decay_step = (fcnt == FC_LAST);

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            fcnt <= '0;
        end else if (frame_bnd) begin
            fcnt <= decay_step ? '0 : fcnt + 1'b1;
        end
    end
`endif

    // Next level, applied only on a frame boundary; load beats decay, then clamp to brightness
    always_comb begin
        for (int i = 0; i < LED_NUM; i++) begin
            level_nx[i] = level[i];
            if (bus.pat_i[i]) begin
                level_nx[i] = bus.bright_i;
            end
`ifdef LED_PWM_FADE_TRAIL_EN
            else if (decay_step) begin
                level_nx[i] = (int'(level[i]) > DECAY) ? level[i] - DECAY_L : '0;
            end
`else
            else begin
                level_nx[i] = '0;
            end
`endif
            if (level_nx[i] > bus.bright_i) begin
                level_nx[i] = bus.bright_i;
            end
        end
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            for (int i = 0; i < LED_NUM; i++) begin
                level[i] <= '0;
            end
        end else if (frame_bnd) begin
            for (int i = 0; i < LED_NUM; i++) begin
                level[i] <= level_nx[i];
            end
        end
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            led_q <= '0;
        end else begin
            for (int i = 0; i < LED_NUM; i++) begin
                led_q[i] <= bus.en_i & (cnt < level[i]);
            end
        end
    end

    assign bus.LED_o   = led_q;
    assign bus.frame_o = frame_q;

endmodule

// File: tb/tb_led_pwm_fade.sv
// Directed bench for led_pwm_fade: 16-cycle frames (PRE_DIV=1, 4-bit PWM), FADE_FRAMES=2, DECAY=4.
// Trail expectations follow LED_PWM_FADE_TRAIL_EN; boundary Bk ends frame Fk-1, even Bk are decay steps.
module tb_led_pwm_fade;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

`ifdef LED_PWM_FADE_TRAIL_EN
    localparam bit TRAIL = 1'b1;
`else
    localparam bit TRAIL = 1'b0;
`endif

    led_pwm_fade_if #(.LED_NUM(8), .PWM_BITS(4)) bus ();

    led_pwm_fade #(
        .CLK_FREQ    (16),
        .LED_NUM     (8),
        .PWM_BITS    (4),
        .PWM_FREQ    (1),
        .FADE_FRAMES (2),
        .DECAY       (4)
    ) dut (
        .CLK_i (clk),
        .RST_i (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Waits (bounded) for frame_o, counting cycles and any LED activity on the way
    task automatic wait_frame(input string tag);
        int cycles = 0;
        int hits   = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (bus.LED_o != 8'h00) hits++;
        end while (!bus.frame_o && cycles < 40);
        check_val({tag, "_latency"}, cycles, 16);
        check_val({tag, "_led_idle"}, hits, 0);
    endtask

    // Measures one full frame starting right after a frame_o sample
    task automatic run_frame(input string tag, input int exp_duty);
        int         duty   = 0;
        int         fr_mid = 0;
        logic       fr_end = 1'b0;
        logic [7:0] others = 8'h00;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (bus.LED_o[0]) duty++;
            others |= bus.LED_o & 8'hFE;
            if (k < 16 && bus.frame_o) fr_mid++;
            if (k == 16) fr_end = bus.frame_o;
        end
        check_val({tag, "_duty"}, duty, exp_duty);
        check_val({tag, "_others"}, others, 0);
        check_val({tag, "_frame_mid"}, fr_mid, 0);
        check_val({tag, "_frame_end"}, fr_end, 1);
    endtask

    initial begin
        int hits;

        rst          = 1'b1;
        bus.pat_i    = 8'hFF;
        bus.bright_i = 4'd8;
        bus.en_i     = 1'b1;

        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val("rst_led", bus.LED_o, 0);
            check_val("rst_frame", bus.frame_o, 0);
        end
        rst       = 1'b0;
        bus.pat_i = 8'h01;
        wait_frame("rst_first");

        // basic duty and boundary-only brightness sampling
        run_frame("F1", 8);
        bus.bright_i = 4'd15;
        run_frame("F2", 8);
        run_frame("F3", 15);
        bus.bright_i = 4'd12;
        run_frame("F4", 15);
        run_frame("F5", 12);

        // trail: 12,12,8,8,4,4,0 with decay, otherwise off from the next boundary
        bus.pat_i = 8'h00;
        run_frame("F6", 12);
        run_frame("F7", TRAIL ? 12 : 0);
        run_frame("F8", TRAIL ? 8 : 0);
        run_frame("F9", TRAIL ? 8 : 0);
        run_frame("F10", TRAIL ? 4 : 0);
        run_frame("F11", TRAIL ? 4 : 0);
        run_frame("F12", 0);

        // load on a decay-step boundary (B14), then brightness clamp on a hold boundary (B15)
        bus.pat_i    = 8'h01;
        bus.bright_i = 4'd8;
        run_frame("F13", 0);
        bus.pat_i    = 8'h00;
        bus.bright_i = 4'd5;
        run_frame("F14_load", 8);
        run_frame("F15_clamp", TRAIL ? 5 : 0);
        run_frame("F16", TRAIL ? 1 : 0);
        run_frame("F17", TRAIL ? 1 : 0);
        run_frame("F18_sat", 0);

        // enable: drop mid-frame, frames keep coming, re-enable realigns
        bus.pat_i    = 8'h01;
        bus.bright_i = 4'd10;
        run_frame("F19", 0);
        for (int k = 1; k <= 4; k++) @(negedge clk);
        check_val("en_pre", bus.LED_o[0], 1);
        bus.en_i = 1'b0;
        @(negedge clk);
        check_val("en_off_next", bus.LED_o, 0);
        hits = 0;
        for (int k = 6; k <= 16; k++) begin
            @(negedge clk);
            if (bus.LED_o != 8'h00) hits++;
        end
        check_val("en_off_hits", hits, 0);
        check_val("en_off_frame", bus.frame_o, 1);
        run_frame("F21_en_off", 0);
        bus.en_i = 1'b1;
        run_frame("F22_en_on", 10);

        // mid-frame reset at cnt=7 with LED 0 high
        for (int k = 1; k <= 7; k++) @(negedge clk);
        check_val("mrst_led_pre", bus.LED_o[0], 1);
        rst = 1'b1;
        @(negedge clk);
        check_val("mrst_led", bus.LED_o, 0);
        check_val("mrst_frame", bus.frame_o, 0);
        rst = 1'b0;
        wait_frame("mrst_first");
        run_frame("F_after_mrst", 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
